multdiv_ctrl: RTL and testbench

// - Sequencer for the iterative multdiv datapath (radix-4 Booth multiplier, non-restoring divider).
// - Latches operands on ctrl_MULT/ctrl_DIV, counts iteration steps and drives per-step datapath enables.
// - Short-circuits divide-by-zero, registers data_exception and pulses data_resultRDY for exactly one cycle.
// - Sits between the processor's multdiv issue logic and the multdiv shift/add datapath.

---
 rtl/multdiv_pkg.sv | 18 +
 rtl/multdiv_ctrl_if.sv | 33 +++
 rtl/gen_reg.sv | 22 ++
 rtl/multdiv_step_counter.sv | 26 ++
 rtl/multdiv_ctrl.sv | 102 ++++++++++
 tb/tb_multdiv_ctrl.sv | 236 +++++++++++++++++++++++
 6 files changed

// File: rtl/multdiv_pkg.sv
// Purpose: shared constants for the multdiv sequencer (FSM encodings, step counts, counter width).
// Latency: n/a (constants only).
// Backpressure: n/a.
package multdiv_pkg;

    // FSM encodings, kept as plain vectors so older tools and dumps can read them
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Radix-4 Booth on 32-bit operands retires 2 bits per step
    localparam int MULT_STEPS_DEF = 16;
    // Non-restoring divide retires 1 quotient bit per step
    localparam int DIV_STEPS_DEF  = 32;
    // Must hold the largest step index (DIV_STEPS_DEF-1)
    localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Purpose: bundle between multdiv issue logic / datapath (master) and the sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: none; starts are single-cycle pulses and are always accepted.
interface multdiv_ctrl_if #(
    parameter int CNT_W = multdiv_pkg::CNT_W_DEF
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [31:0]      data_operandA;
    logic [31:0]      data_operandB;
    logic             dp_overflow;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             is_div;
    logic             step_en;
    logic             first_step;
    logic [CNT_W-1:0] step_cnt;
    logic             busy;
    logic             data_resultRDY;
    logic             data_exception;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, dp_overflow,
        input  op_a, op_b, is_div, step_en, first_step, step_cnt, busy,
               data_resultRDY, data_exception
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, dp_overflow,
        output op_a, op_b, is_div, step_en, first_step, step_cnt, busy,
               data_resultRDY, data_exception
    );
endinterface

// File: rtl/gen_reg.sv
// Purpose: generic write-enabled register with synchronous active-high clear.
// Latency: 1 cycle from en_i to q_o.
// Backpressure: none; holds its value whenever en_i is low.
module gen_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;

    // Clear wins over a write so a reset in the start cycle leaves zeros
    always_ff @(posedge clk_i) begin
        if (rst_i)     data_q <= '0;
        else if (en_i) data_q <= d_i;
    end

    assign q_o = data_q;
endmodule

// File: rtl/multdiv_step_counter.sv
// Purpose: datapath step index with sync clear, enable and terminal-count flag at last_i.
// Latency: 1 cycle from clr_i/en_i to cnt_o; tc_o is combinational on cnt_o.
// Backpressure: none; caller gates en_i with tc_o so the count saturates.
module multdiv_step_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] last_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q;

    // Clear (new op) has priority over counting
    always_ff @(posedge clk_i) begin
        if (rst_i)      cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i)  cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);
endmodule

// File: rtl/multdiv_ctrl.sv
// Purpose: sequencer for the iterative multdiv datapath (Booth multiply, non-restoring divide).
// Latency: N = 16 (mul) / 32 (div) step cycles, ready pulse on the edge after the last step; div-by-zero ready on the start edge.
// Backpressure: none; a new start at any time abandons the op in flight, reset aborts silently.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MULT_STEPS = MULT_STEPS_DEF,
    parameter int DIV_STEPS  = DIV_STEPS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic         clock,
    input  logic         ctrl_reset,
    multdiv_ctrl_if.slave bus
);
    logic [1:0]       state_q, state_d;
    logic             rdy_q;
    logic             exc_q, exc_d;
    logic             start, start_div, div0;
    logic             tc, cnt_en;
    logic [CNT_W-1:0] cnt, last_step;
    logic             is_div_q;
    logic [31:0]      op_a_q, op_b_q;

    // Multiply wins when both starts are high
    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign div0      = start_div && (bus.data_operandB == 32'd0);
    assign last_step = is_div_q ? CNT_W'(DIV_STEPS - 1) : CNT_W'(MULT_STEPS - 1);
    // Stop counting at the last step so the index saturates instead of wrapping
    assign cnt_en    = (state_q == ST_RUN) && !tc;

    gen_reg #(.WIDTH(32)) u_op_a (
        .clk_i(clock), .rst_i(ctrl_reset), .en_i(start),
        .d_i(bus.data_operandA), .q_o(op_a_q)
    );

    gen_reg #(.WIDTH(32)) u_op_b (
        .clk_i(clock), .rst_i(ctrl_reset), .en_i(start),
        .d_i(bus.data_operandB), .q_o(op_b_q)
    );

    gen_reg #(.WIDTH(1)) u_is_div (
        .clk_i(clock), .rst_i(ctrl_reset), .en_i(start),
        .d_i(start_div), .q_o(is_div_q)
    );

    multdiv_step_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i(clock), .rst_i(ctrl_reset), .clr_i(start), .en_i(cnt_en),
        .last_i(last_step), .cnt_o(cnt), .tc_o(tc)
    );

    // Next state and the exception value that accompanies an entry into DONE
    always_comb begin
        state_d = state_q;
        exc_d   = 1'b0;
        if (start) begin
            // A start always restarts, even mid-op or on the edge that would finish
            if (div0) begin
                state_d = ST_DONE;
                exc_d   = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tc) begin
                        state_d = ST_DONE;
                        // Divide never overflows; only the final multiply step counts
                        exc_d   = !is_div_q && bus.dp_overflow;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State plus ready/exception registers; ready is high exactly while in DONE
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == ST_DONE);
            exc_q   <= (state_d == ST_DONE) && exc_d;
        end
    end

    assign bus.op_a           = op_a_q;
    assign bus.op_b           = op_b_q;
    assign bus.is_div         = is_div_q;
    assign bus.busy           = (state_q == ST_RUN);
    assign bus.step_en        = (state_q == ST_RUN);
    assign bus.first_step     = (state_q == ST_RUN) && (cnt == '0);
    assign bus.step_cnt       = cnt;
    assign bus.data_resultRDY = rdy_q;
    assign bus.data_exception = exc_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Purpose: randomized + directed check of multdiv_ctrl against a cycle-indexed reference model.
// Latency: model predicts step windows and ready cycles from the start edge.
// Backpressure: n/a.
module tb_multdiv_ctrl;
    localparam int MAXC = 4096;

    typedef struct {
        int due;
        bit exc;
    } exp_t;

    logic clock;
    logic ctrl_reset;
    int   cyc;
    int   mon_from;
    int   total;
    int   bad;

    // Expected per-cycle view, indexed by the number of rising edges seen so far
    bit          exp_step [MAXC];
    int          exp_cnt  [MAXC];
    logic [31:0] exp_a    [MAXC];
    logic [31:0] exp_b    [MAXC];
    bit          exp_div  [MAXC];
    bit          ovf_plan [MAXC];
    exp_t        sb[$];

    multdiv_ctrl_if #(.CNT_W(6)) bus ();

    multdiv_ctrl dut (
        .clock(clock),
        .ctrl_reset(ctrl_reset),
        .bus(bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
        end
    endtask

    // One idle cycle: drop starts/reset, toggle operand inputs, drive planned overflow
    task automatic step();
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        ctrl_reset        = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        bus.dp_overflow   = (cyc < MAXC) ? ovf_plan[cyc] : 1'b0;
    endtask

    // Drop any pending result whose ready edge is at or after edge e
    task automatic abandon_from(input int e);
        while (sb.size() > 0 && sb[$].due >= e) void'(sb.pop_back());
    endtask

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                            input bit ovl, input bit ove);
        int  s, n;
        bit  isdiv, div0;
        exp_t e;
        step();
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        s     = cyc + 1;
        isdiv = d && !m;
        div0  = isdiv && (b == 32'd0);
        n     = isdiv ? 32 : 16;
        abandon_from(s);
        for (int c = s; c < MAXC; c++) begin
            exp_step[c] = 1'b0;
            exp_a[c]    = a;
            exp_b[c]    = b;
            exp_div[c]  = isdiv;
            exp_cnt[c]  = div0 ? 0 : ((c - s < n) ? (c - s) : (n - 1));
        end
        if (div0) begin
            e.due = s;
            e.exc = 1'b1;
        end else begin
            for (int k = 0; k < n; k++) begin
                if (s + k < MAXC) begin
                    exp_step[s + k] = 1'b1;
                    ovf_plan[s + k] = (k == n - 1) ? ovl : (ove && (k == n / 2));
                end
            end
            e.due = s + n;
            e.exc = !isdiv && ovl;
        end
        sb.push_back(e);
    endtask

    task automatic reset_op(input bit with_start);
        int r;
        step();
        ctrl_reset = 1'b1;
        if (with_start) begin
            bus.ctrl_MULT     = 1'b1;
            bus.data_operandA = $urandom;
        end
        r = cyc + 1;
        abandon_from(r);
        for (int c = r; c < MAXC; c++) begin
            exp_step[c] = 1'b0;
            exp_cnt[c]  = 0;
            exp_a[c]    = '0;
            exp_b[c]    = '0;
            exp_div[c]  = 1'b0;
        end
        if (mon_from > r) mon_from = r;
    endtask

    // Monitor: per-cycle output checks and scoreboard pops on every ready pulse
    always @(negedge clock) begin
        if (cyc >= mon_from && cyc < MAXC) begin
            check("step_en", 32'(bus.step_en), 32'(exp_step[cyc]));
            check("busy", 32'(bus.busy), 32'(exp_step[cyc]));
            check("first_step", 32'(bus.first_step), 32'(exp_step[cyc] && exp_cnt[cyc] == 0));
            check("step_cnt", 32'(bus.step_cnt), 32'(exp_cnt[cyc]));
            check("op_a", bus.op_a, exp_a[cyc]);
            check("op_b", bus.op_b, exp_b[cyc]);
            check("is_div", 32'(bus.is_div), 32'(exp_div[cyc]));
            if (bus.data_resultRDY === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_ready cyc=%0d got=1 want=0", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ready_cycle", 32'(cyc), 32'(e.due));
                    check("exception", 32'(bus.data_exception), 32'(e.exc));
                end
            end else begin
                check("ready_level", 32'(bus.data_resultRDY), 32'd0);
                check("exc_unqualified", 32'(bus.data_exception), 32'd0);
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missed_ready cyc=%0d got=none want_at=%0d", cyc, sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int kind, gap, n;
        logic [31:0] b;
        cyc        = 0;
        total      = 0;
        bad        = 0;
        mon_from   = MAXC;
        ctrl_reset = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.dp_overflow   = 1'b0;
        for (int c = 0; c < MAXC; c++) ovf_plan[c] = 1'b0;

        reset_op(1'b0);
        repeat (3) step();

        // 7 x 6: 16 steps, operands held while inputs toggle
        start_op(1'b1, 1'b0, 32'd7, 32'd6, 1'b0, 1'b1);
        repeat (20) step();
        // 100 / 0: immediate ready with exception, no steps
        start_op(1'b0, 1'b1, 32'd100, 32'd0, 1'b0, 1'b0);
        repeat (5) step();
        // 100 / 7: 32 steps, no exception
        start_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, 1'b0);
        repeat (36) step();
        // Overflow in final multiply step vs. only in an earlier step
        start_op(1'b1, 1'b0, 32'h7fff_ffff, 32'd3, 1'b1, 1'b0);
        repeat (20) step();
        start_op(1'b1, 1'b0, 32'h1234, 32'd5, 1'b0, 1'b1);
        repeat (20) step();
        // Restart: divide, then multiply 10 edges later abandons the divide
        start_op(1'b0, 1'b1, 32'd500, 32'd9, 1'b1, 1'b0);
        repeat (9) step();
        start_op(1'b1, 1'b0, 32'd11, 32'd13, 1'b0, 1'b0);
        repeat (40) step();
        // Reset five edges into a multiply
        start_op(1'b1, 1'b0, 32'd21, 32'd2, 1'b0, 1'b0);
        repeat (4) step();
        reset_op(1'b0);
        repeat (20) step();
        // Both starts high: a multiply, even with divisor 0
        start_op(1'b1, 1'b1, 32'd9, 32'd0, 1'b0, 1'b0);
        repeat (20) step();
        // Start on the edge that would enter DONE, then a start during DONE
        start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b1, 1'b0);
        repeat (15) step();
        start_op(1'b1, 1'b0, 32'd5, 32'd6, 1'b0, 1'b0);
        repeat (16) step();
        start_op(1'b0, 1'b1, 32'd8, 32'd0, 1'b0, 1'b0);
        repeat (10) step();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                reset_op(1'($urandom_range(0, 1)));
                repeat ($urandom_range(1, 4)) step();
            end else begin
                kind = $urandom_range(0, 2);
                b    = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
                n    = (kind == 1) ? 32 : 16;
                start_op(kind != 1, kind != 0, 32'($urandom), b,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                gap = $urandom_range(0, n + 3);
                repeat (gap) step();
            end
        end

        repeat (60) step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL pending_at_end got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
